// File: rtl/nes_joypad_ps2_pkg.sv
// Shared constants for the NES joypad-1 PS/2 stage: button bit indices,
// PS/2 set-2 scancodes, CPU register addresses and the scancode-to-button map.
package nes_joypad_ps2_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [7:0] SC_X       = 8'h22;
  localparam logic [7:0] SC_Z       = 8'h1A;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_TURBO_A = 8'h1C;
  localparam logic [7:0] SC_TURBO_B = 8'h1B;

  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;
  localparam logic [7:0]  OPEN_BUS  = 8'h40;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = '0;
    case ({ext, code})
      {1'b0, SC_X}:     m.idx = 3'(BTN_A);
      {1'b0, SC_Z}:     m.idx = 3'(BTN_B);
      {1'b0, SC_SPACE}: m.idx = 3'(BTN_SELECT);
      {1'b0, SC_ENTER}: m.idx = 3'(BTN_START);
      {1'b1, SC_UP}:    m.idx = 3'(BTN_UP);
      {1'b1, SC_DOWN}:  m.idx = 3'(BTN_DOWN);
      {1'b1, SC_LEFT}:  m.idx = 3'(BTN_LEFT);
      {1'b1, SC_RIGHT}: m.idx = 3'(BTN_RIGHT);
      default:          m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge
// detect, 11-bit frame FSM with odd-parity check and mid-frame timeout.
module ps2_rx
  import nes_joypad_ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rxbyte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_s_q;
  logic [1:0]    dat_s_q;
  rx_state_e     state_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [TW-1:0] tmo_q;
  logic          fall;
  logic          dat;

  assign fall = clk_s_q[2] & ~clk_s_q[1];
  assign dat  = dat_s_q[1];

  // Parity and stop are judged together at the stop bit so a bad frame
  // yields exactly one error pulse and never re-enters via the stop edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s_q    <= '1;
      dat_s_q    <= '1;
      state_q    <= RX_IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      rxbyte     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s_q    <= {clk_s_q[1:0], ps2_clk};
      dat_s_q    <= {dat_s_q[0], ps2_dat};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          RX_IDLE: begin
            if (!dat) begin
              state_q <= RX_DATA;
              bit_q   <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q <= {dat, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok_q <= ^{shift_q, dat};
            state_q  <= RX_STOP;
          end
          RX_STOP: begin
            if (dat && par_ok_q) begin
              rxbyte     <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (state_q != RX_IDLE) begin
        if (tmo_q == TW'(TIMEOUT_CYC)) begin
          state_q   <= RX_IDLE;
          frame_err <= 1'b1;
          tmo_q     <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nes_joypad_ps2.sv
// NES joypad-1 on the CPU bus fed by a PS/2 keyboard: scancode decoder, pad
// latch and $4016 strobe/shift register. Turbo keys under JOYPAD_TURBO_EN.
module nes_joypad_ps2
  import nes_joypad_ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 25000,
  parameter int unsigned TURBO_DIV   = 1250000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic [15:0] address,
  input  logic        we,
  input  logic        rd,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        sel,
  output logic [7:0]  buttons,
  output logic        frame_err
);

  if (TIMEOUT_CYC == 0 || TURBO_DIV == 0) begin : g_cfg_err
    $error("TIMEOUT_CYC and TURBO_DIV must be non-zero");
  end

  logic [7:0] rxbyte;
  logic       byte_valid;
  key_map_t   key;
  logic       ext_q, brk_q, strobe_q, rd_prev_q, shift_pend_q;
  logic [7:0] btn_q, sr_q, q_q, eff_buttons;
  logic       unused_d;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rxbyte     (rxbyte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign key      = map_key(ext_q, rxbyte);
  assign unused_d = &{1'b0, d[7:1]};

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned DW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [1:0]    turbo_q;
  logic          phase_q;
  logic [DW-1:0] div_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      turbo_q <= '0;
      phase_q <= 1'b0;
      div_q   <= '0;
    end else begin
      if (div_q == DW'(TURBO_DIV - 1)) begin
        div_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (byte_valid && !ext_q && rxbyte == SC_TURBO_A) turbo_q[0] <= ~brk_q;
      if (byte_valid && !ext_q && rxbyte == SC_TURBO_B) turbo_q[1] <= ~brk_q;
    end
  end

  assign eff_buttons = btn_q | {6'b0, turbo_q & {2{phase_q}}};
`else
  assign eff_buttons = btn_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      btn_q <= '0;
    end else if (byte_valid) begin
      if (rxbyte == SC_EXT) begin
        ext_q <= 1'b1;
      end else if (rxbyte == SC_BRK) begin
        brk_q <= 1'b1;
      end else begin
        if (key.hit) btn_q[key.idx] <= ~brk_q;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // The shift is deferred one clock behind the rd edge so q, sampled on the
  // edge, keeps presenting the bit being read for the whole read cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q     <= 1'b0;
      rd_prev_q    <= 1'b0;
      shift_pend_q <= 1'b0;
      sr_q         <= '0;
      q_q          <= OPEN_BUS;
    end else begin
      rd_prev_q    <= rd;
      shift_pend_q <= rd && !rd_prev_q && (address == JOY1_ADDR) && !strobe_q;
      if (we && address == JOY1_ADDR) strobe_q <= d[0];
      if (strobe_q)          sr_q <= eff_buttons;
      else if (shift_pend_q) sr_q <= {1'b1, sr_q[7:1]};
      q_q <= (address == JOY1_ADDR) ? {7'b0100000, sr_q[0]} : OPEN_BUS;
    end
  end

  assign sel     = (address == JOY1_ADDR) || (address == JOY2_ADDR);
  assign q       = q_q;
  assign buttons = btn_q;

endmodule
